sal_wr_ctrl: RTL and testbench
==============================

SAL_WR_CTRL -- requirements
Module: SAL_WR_CTRL

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning AXI W beat width and DFI wrdata width (one beat per DFI cycle).
REQ-002 SHALL have parameter ID_WIDTH, default 4, meaning AXI write ID width.
REQ-003 SHALL have parameter WDATA_DEPTH, default 16, meaning W data FIFO depth in beats.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sched_timing_if  input  t_wl[3:0]  write latency, grant to first wrdata_en, in cycles.
REQ-007 SHALL have port sched_if  input  wr_gnt(1), wr_id(ID_WIDTH), wr_len(4)  scheduler write-command grant, len = beats-1.
REQ-008 SHALL have port sched_if  output  wr_rdy(1)  a write command may be granted this cycle.
REQ-009 SHALL have port axi_w_if (DST)  input/output  wvalid, wdata, wstrb(DATA_WIDTH/8), wlast / wready  AXI W channel.
REQ-010 SHALL have port axi_b_if (SRC)  output/input  bvalid, bid, bresp(2) / bready  AXI B channel.
REQ-011 SHALL have port dfi_wr_if (SRC)  output  wrdata_en(1), wrdata(DATA_WIDTH), wrdata_mask(DATA_WIDTH/8)  DFI write data.
REQ-012 SHALL have port err_o  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL set wready = W FIFO not full; push {wdata, ~wstrb, wlast} on wvalid&&wready.
REQ-014 SHALL keep burst counter bursts_avail: +1 per accepted beat with wlast, -1 per wr_gnt; simultaneous +1/-1 leaves it unchanged.
REQ-015 SHALL drive wr_rdy = (bursts_avail!=0) && (cmd queue has free slot) && (in-flight cmds + B FIFO entries < 4).
REQ-016 SHALL hold a 2-entry cmd queue {id, len, countdown}; wr_gnt loads countdown = max(t_wl,1)-1; every non-zero entry countdown decrements each cycle, saturating at 0.
REQ-017 SHALL use FSM IDLE/STREAM: IDLE->STREAM when head countdown==0; STREAM drives wrdata_en=1 and pops one FIFO beat per cycle for len+1 cycles; last beat -> pop head, push id to B FIFO, go IDLE or stay STREAM if next head countdown==0 (no bubble).
REQ-018 SHALL place the first wrdata_en of a command exactly max(t_wl,1) cycles after the cycle wr_gnt is sampled, when not blocked by a prior burst.
REQ-019 SHALL, if head countdown reaches 0 while a prior burst is still streaming, start it immediately after (late) and set err_o.
REQ-020 SHALL set err_o on wr_gnt while wr_rdy==0 and ignore that grant.
REQ-021 SHALL set err_o if a FIFO beat popped as last of a burst lacks wlast, or a non-last beat carries wlast.
REQ-022 SHALL drive wrdata/wrdata_mask to 0 when wrdata_en==0.
REQ-023 SHALL present B FIFO (depth 4) head as bvalid/bid, bresp=2'b00; pop on bvalid&&bready; push and pop in same cycle allowed.
REQ-024 SHALL never underflow the W FIFO, since grants require a complete buffered burst.

Reset
REQ-025 SHALL, on rst_n low, clear FIFOs, cmd queue, counters and FSM to IDLE asynchronously, including mid-burst.
REQ-026 SHALL reset outputs: wready=0 (1 from first cycle after release), wr_rdy=0, wrdata_en=0, wrdata=0, wrdata_mask=0, bvalid=0, bid=0, bresp=0, err_o=0.

Structure
REQ-027 SHALL define wr_cmd_t {id, len, countdown} and B FIFO depth constant in the shared SAL DDR package; widths from SAL_DDR_PARAMS.svh.
REQ-028 SHALL instantiate sub-module SAL_FIFO (parameterised sync FIFO, full/empty/count) for W data and B FIFOs.

Verification
REQ-029 SHALL cover: 4-beat burst id=3 buffered, t_wl=3, grant at cycle 10 -> wrdata_en cycles 13-16, data in order, bvalid bid=3 at 17.
REQ-030 SHALL cover: wstrb=8'hF0 -> wrdata_mask=8'h0F on that beat.
REQ-031 SHALL cover: two 2-beat bursts, grants 2 cycles apart, t_wl=5 -> 4 contiguous wrdata_en cycles, err_o=0.
REQ-032 SHALL cover: 17 beats offered without grant -> wready low after 16; wr_gnt with wr_rdy=0 -> ignored, err_o=1.
REQ-033 SHALL cover: bready held 0 -> wr_rdy drops once 4 responses pending/in flight; no B entry lost.
REQ-034 SHALL cover: rst_n asserted mid-STREAM -> wrdata_en=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/sal_wr_ctrl_pkg.sv
// rtl/sal_wr_ctrl_pkg.sv - shared types and constants for the SAL DDR write-data controller
package sal_wr_ctrl_pkg;

  localparam int SAL_CMD_ID_W     = 16;
  localparam int SAL_LEN_W        = 4;
  localparam int SAL_CD_W         = 4;
  localparam int SAL_B_DEPTH      = 4;
  localparam int SAL_MAX_INFLIGHT = 4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } wr_state_e;

  // id is sized for the widest supported ID_WIDTH; the top uses the low bits only
  typedef struct packed {
    logic [SAL_CMD_ID_W-1:0] id;
    logic [SAL_LEN_W-1:0]    len;
    logic [SAL_CD_W-1:0]     countdown;
  } wr_cmd_t;

  function automatic logic [SAL_CD_W-1:0] wl_load(input logic [3:0] t_wl);
    return (t_wl == 4'd0) ? 4'd0 : t_wl - 4'd1;
  endfunction

  function automatic logic [SAL_CD_W-1:0] sat_dec(input logic [SAL_CD_W-1:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/sal_wr_ctrl_fifo.sv
// rtl/sal_wr_ctrl_fifo.sv - parameterised synchronous FIFO with full/empty/count
module sal_wr_ctrl_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // storage is left out of reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sal_wr_ctrl.sv
// rtl/sal_wr_ctrl.sv - AXI W/B to DFI write-data controller with write-latency scheduling
module sal_wr_ctrl
  import sal_wr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 4,
  parameter int WDATA_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              t_wl_i,
  input  logic                    wr_gnt_i,
  input  logic [ID_WIDTH-1:0]     wr_id_i,
  input  logic [3:0]              wr_len_i,
  output logic                    wr_rdy_o,
  input  logic                    wvalid_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    wready_o,
  output logic                    bvalid_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  input  logic                    bready_i,
  output logic                    wrdata_en_o,
  output logic [DATA_WIDTH-1:0]   wrdata_o,
  output logic [DATA_WIDTH/8-1:0] wrdata_mask_o,
  output logic                    err_o
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int WW  = DATA_WIDTH + SW + 1;
  localparam int WCW = $clog2(WDATA_DEPTH + 1);
  localparam int BCW = $clog2(SAL_B_DEPTH + 1);

  logic            init_q;
  wr_state_e       state_q;
  logic [3:0]      beat_q;
  logic            err_q;
  logic [WCW-1:0]  bursts_q, bursts_d;
  wr_cmd_t         cq_q [2];
  wr_cmd_t         cq_d [2];
  logic [1:0]      cq_vld_q, cq_vld_d;
  wr_cmd_t         new_cmd;

  logic            stream, is_last, gnt_ok, due_d, err_set;
  logic [2:0]      pend;

  logic            w_push, w_full, w_empty;
  logic [WW-1:0]   w_rdata;
  logic [WCW-1:0]  w_count;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic [SW-1:0]   w_beat_mask;
  logic            w_beat_last;

  logic [ID_WIDTH-1:0] b_rdata;
  logic            b_full, b_empty;
  logic [BCW-1:0]  b_count;
  logic            unused_ok;

  assign wready_o    = init_q && !w_full;
  assign w_push      = wvalid_i && wready_o;
  assign w_beat_data = w_rdata[WW-1 -: DATA_WIDTH];
  assign w_beat_mask = w_rdata[SW:1];
  assign w_beat_last = w_rdata[0];
  assign unused_ok   = ^{w_count, cq_q[0].id};

  sal_wr_ctrl_fifo #(.WIDTH(WW), .DEPTH(WDATA_DEPTH)) u_w_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  ({wdata_i, ~wstrb_i, wlast_i}),
    .pop_i   (stream),
    .data_o  (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  sal_wr_ctrl_fifo #(.WIDTH(ID_WIDTH), .DEPTH(SAL_B_DEPTH)) u_b_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (is_last),
    .data_i  (cq_q[0].id[ID_WIDTH-1:0]),
    .pop_i   (bvalid_o && bready_i),
    .data_o  (b_rdata),
    .full_o  (b_full),
    .empty_o (b_empty),
    .count_o (b_count)
  );

  assign bvalid_o      = !b_empty;
  assign bid_o         = bvalid_o ? b_rdata : '0;
  assign bresp_o       = 2'b00;
  assign wrdata_en_o   = stream;
  assign wrdata_o      = stream ? w_beat_data : '0;
  assign wrdata_mask_o = stream ? w_beat_mask : '0;
  assign err_o         = err_q;

  always_comb begin
    stream   = (state_q == ST_STREAM);
    is_last  = stream && (beat_q == cq_q[0].len);
    pend     = 3'(cq_vld_q[0]) + 3'(cq_vld_q[1]) + 3'(b_count);
    wr_rdy_o = init_q && (bursts_q != '0) && !cq_vld_q[1] && (pend < 3'(SAL_MAX_INFLIGHT));
    gnt_ok   = wr_gnt_i && wr_rdy_o;
    bursts_d = bursts_q + WCW'(w_push && wlast_i) - WCW'(gnt_ok);

    new_cmd                  = '0;
    new_cmd.id[ID_WIDTH-1:0] = wr_id_i;
    new_cmd.len              = wr_len_i;
    new_cmd.countdown        = wl_load(t_wl_i);

    // age, then retire the streaming head, then append the new grant
    for (int i = 0; i < 2; i++) begin
      cq_d[i]           = cq_q[i];
      cq_d[i].countdown = sat_dec(cq_q[i].countdown);
    end
    cq_vld_d = cq_vld_q;
    if (is_last) begin
      cq_d[0]  = cq_d[1];
      cq_vld_d = {1'b0, cq_vld_q[1]};
    end
    if (gnt_ok) begin
      if (!cq_vld_d[0]) begin
        cq_d[0]     = new_cmd;
        cq_vld_d[0] = 1'b1;
      end else begin
        cq_d[1]     = new_cmd;
        cq_vld_d[1] = 1'b1;
      end
    end
    // the FSM looks at next cycle's head so wrdata_en lands exactly t_wl after the grant
    due_d = cq_vld_d[0] && (cq_d[0].countdown == 4'd0);

    err_set = (wr_gnt_i && !wr_rdy_o)
           || (stream && (w_empty || (w_beat_last != is_last)))
           || (stream && cq_vld_q[1] && (cq_q[1].countdown == 4'd0))
           || (is_last && b_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      bursts_q <= '0;
      cq_q[0]  <= '0;
      cq_q[1]  <= '0;
      cq_vld_q <= '0;
      err_q    <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      bursts_q <= bursts_d;
      cq_q[0]  <= cq_d[0];
      cq_q[1]  <= cq_d[1];
      cq_vld_q <= cq_vld_d;
      err_q    <= err_q || err_set;
      case (state_q)
        ST_IDLE: begin
          if (due_d) begin
            state_q <= ST_STREAM;
            beat_q  <= '0;
          end
        end
        ST_STREAM: begin
          if (!is_last) begin
            beat_q <= beat_q + 4'd1;
          end else if (due_d) begin
            beat_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sal_wr_ctrl.sv
// tb/tb_sal_wr_ctrl.sv - directed self-checking bench for sal_wr_ctrl
module tb_sal_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  t_wl;
  logic        wr_gnt;
  logic [3:0]  wr_id;
  logic [3:0]  wr_len;
  logic        wr_rdy;
  logic        wvalid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wready;
  logic        bvalid;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bready;
  logic        wrdata_en;
  logic [63:0] wrdata;
  logic [7:0]  wrdata_mask;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sal_wr_ctrl #(.DATA_WIDTH(64), .ID_WIDTH(4), .WDATA_DEPTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .t_wl_i        (t_wl),
    .wr_gnt_i      (wr_gnt),
    .wr_id_i       (wr_id),
    .wr_len_i      (wr_len),
    .wr_rdy_o      (wr_rdy),
    .wvalid_i      (wvalid),
    .wdata_i       (wdata),
    .wstrb_i       (wstrb),
    .wlast_i       (wlast),
    .wready_o      (wready),
    .bvalid_o      (bvalid),
    .bid_o         (bid),
    .bresp_o       (bresp),
    .bready_i      (bready),
    .wrdata_en_o   (wrdata_en),
    .wrdata_o      (wrdata),
    .wrdata_mask_o (wrdata_mask),
    .err_o         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] pat(input int id, input int b);
    return {32'hA5A5_0000 + 32'(id), 32'(b)};
  endfunction

  task automatic push_burst(input int id, input int n, input bit odd_strb);
    for (int b = 0; b < n; b++) begin
      chk($sformatf("push_wready_id%0d_b%0d", id, b), wready, 1);
      wvalid = 1'b1;
      wdata  = pat(id, b);
      wstrb  = (odd_strb && b == 1) ? 8'hF0 : 8'hFF;
      wlast  = (b == n - 1);
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_wr_rdy"}, wr_rdy, 0);
    chk({tag, "_wrdata_en"}, wrdata_en, 0);
    chk({tag, "_wrdata"}, wrdata, 0);
    chk({tag, "_mask"}, wrdata_mask, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bid"}, bid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; t_wl = 4'd0; wr_gnt = 1'b0; wr_id = '0; wr_len = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
    repeat (3) tick();
    check_idle_outputs("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_release_wready", wready, 1);
    chk("rst_release_wr_rdy", wr_rdy, 0);

    // 4-beat burst id 3, t_wl 3, second beat masked upper half
    t_wl = 4'd3;
    push_burst(3, 4, 1'b1);
    chk("t1_wr_rdy", wr_rdy, 1);
    wr_gnt = 1'b1; wr_id = 4'd3; wr_len = 4'd3;
    for (int k = 1; k <= 7; k++) begin
      tick();
      wr_gnt = 1'b0;
      chk($sformatf("t1_en_k%0d", k), wrdata_en, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        chk($sformatf("t1_data_k%0d", k), wrdata, pat(3, k - 3));
        chk($sformatf("t1_mask_k%0d", k), wrdata_mask, (k == 4) ? 8'h0F : 8'h00);
      end else begin
        chk($sformatf("t1_data0_k%0d", k), wrdata, 0);
        chk($sformatf("t1_mask0_k%0d", k), wrdata_mask, 0);
      end
      if (k == 6) chk("t1_bvalid_early", bvalid, 0);
    end
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bid", bid, 3);
    chk("t1_bresp", bresp, 0);
    chk("t1_err", err, 0);

    // two 2-beat bursts granted 2 cycles apart, t_wl 5: back-to-back on DFI
    t_wl = 4'd5;
    push_burst(5, 2, 1'b0);
    push_burst(6, 2, 1'b0);
    wr_gnt = 1'b1; wr_id = 4'd5; wr_len = 4'd1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      wr_gnt = (k == 2);
      wr_id  = 4'd6;
      chk($sformatf("t2_en_k%0d", k), wrdata_en, (k >= 5 && k <= 8));
      if (k >= 5 && k <= 8)
        chk($sformatf("t2_data_k%0d", k), wrdata, (k <= 6) ? pat(5, k - 5) : pat(6, k - 7));
      if (k == 7) begin
        chk("t2_bvalid_a", bvalid, 1);
        chk("t2_bid_a", bid, 5);
      end
      if (k == 9) begin
        chk("t2_bvalid_b", bvalid, 1);
        chk("t2_bid_b", bid, 6);
      end
    end
    chk("t2_err", err, 0);

    // bready held low: wr_rdy drops once 4 responses pending
    t_wl = 4'd1;
    bready = 1'b0;
    for (int i = 0; i < 5; i++) push_burst(8 + i, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_wr_rdy_i%0d", i), wr_rdy, (i < 4));
      wr_gnt = (i < 4);
      wr_id  = 4'(8 + i);
      wr_len = 4'd0;
      tick();
    end
    wr_gnt = 1'b0;
    tick();
    chk("t4_wr_rdy_held", wr_rdy, 0);
    chk("t4_bvalid_held", bvalid, 1);
    chk("t4_bid_held", bid, 8);
    bready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t4_bvalid_j%0d", j), bvalid, 1);
      chk($sformatf("t4_bid_j%0d", j), bid, 8 + j);
      tick();
    end
    chk("t4_bvalid_drained", bvalid, 0);
    chk("t4_wr_rdy_back", wr_rdy, 1);
    wr_gnt = 1'b1; wr_id = 4'd12; wr_len = 4'd0;
    tick();
    wr_gnt = 1'b0;
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    chk("t4_bvalid_last", bvalid, 1);
    chk("t4_bid_last", bid, 12);
    chk("t4_err", err, 0);

    // reset asserted in the middle of a stream
    t_wl = 4'd2;
    push_burst(7, 4, 1'b0);
    wr_gnt = 1'b1; wr_id = 4'd7; wr_len = 4'd3;
    tick();
    wr_gnt = 1'b0;
    tick();
    tick();
    chk("t5_en_mid", wrdata_en, 1);
    chk("t5_data_mid", wrdata, pat(7, 1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_wready_after", wready, 1);
    chk("t5_wr_rdy_after", wr_rdy, 0);
    chk("t5_en_after", wrdata_en, 0);
    chk("t5_bvalid_after", bvalid, 0);

    // 17 beats with no grant: FIFO fills at 16; a grant while not ready is flagged
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t3_wready_i%0d", i), wready, (i < 16));
      wvalid = 1'b1;
      wdata  = pat(1, i);
      wstrb  = 8'hFF;
      wlast  = 1'b0;
      tick();
    end
    wvalid = 1'b0;
    chk("t3_wready_full", wready, 0);
    chk("t3_wr_rdy", wr_rdy, 0);
    chk("t3_err_before", err, 0);
    wr_gnt = 1'b1; wr_id = 4'd1; wr_len = 4'd0;
    tick();
    wr_gnt = 1'b0;
    chk("t3_err_after", err, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_en_k%0d", k), wrdata_en, 0);
    end
    chk("t3_bvalid", bvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
